load_store_unit: RTL and testbench

Multi-cycle load/store unit replacing the core's fixed word-only memory stage. Accepts one load/store request per transaction from the execute stage over a valid/ready handshake. Issues an aligned, byte-masked access to a data-memory port and returns a sign- or zero-extended result. Supports byte/half/word (and double when XLEN=64) accesses, misalignment detection, and memory backpressure.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_align.sv | 26 ++
 rtl/load_store_unit.sv | 103 ++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and size/alignment helpers for the load/store unit
package lsu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_t;

   function automatic logic [7:0] size_mask(input logic [2:0] funct3);
      return funct3[1:0] == 2'd0 ? 8'h01 : funct3[1:0] == 2'd1 ? 8'h03 :
             funct3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
   endfunction

   // (1 << size) - 1 wraps to 3'b111 for doubles, giving the low-bit alignment mask
   function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
      return |(addr_lo & ((3'd1 << funct3[1:0]) - 3'd1));
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for store data/mask and load extraction with extension
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]                  funct3,
   input  logic [$clog2(XLEN/8)-1:0]   lane,
   input  logic [XLEN-1:0]             wdata,
   input  logic [XLEN-1:0]             rdata,
   output logic [XLEN/8-1:0]           wmask,
   output logic [XLEN-1:0]             wdata_sh,
   output logic [XLEN-1:0]             ldata
);
   localparam int STRB_W = XLEN / 8;
   logic [XLEN-1:0] sh;
   assign wmask    = STRB_W'(size_mask(funct3)) << lane;
   assign wdata_sh = wdata << {lane, 3'b000};
   assign sh       = rdata >> {lane, 3'b000};
   assign ldata    = funct3 == F3_B  ? XLEN'($signed(sh[7:0]))  :
                     funct3 == F3_H  ? XLEN'($signed(sh[15:0])) :
                     funct3 == F3_W  ? XLEN'($signed(sh[31:0])) :
                     funct3 == F3_BU ? XLEN'(sh[7:0])           :
                     funct3 == F3_HU ? XLEN'(sh[15:0])          :
                     funct3 == F3_WU ? XLEN'(sh[31:0])          : sh;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle byte/half/word/double load/store with alignment checks and backpressure
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32,
   parameter int STRB_W = XLEN / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [STRB_W-1:0] mem_wmask,
   input  logic              mem_resp_valid,
   input  logic [XLEN-1:0]   mem_rdata
);
   localparam int LW = $clog2(STRB_W);
   state_t state;
   logic [2:0] f3_q, f3;
   logic [LW-1:0] lane_q, lane;
   logic [STRB_W-1:0] wmask;
   logic [XLEN-1:0] wdata_sh, ldata;
   logic illegal, err;
   // the aligner sees the live request while idle and the latched one afterwards
   assign f3   = state == IDLE ? req_funct3 : f3_q;
   assign lane = state == IDLE ? req_addr[LW-1:0] : lane_q;
   assign illegal = req_we ? req_funct3[2] || (XLEN == 32 && req_funct3 == F3_D)
                           : req_funct3 == 3'b111 ||
                             (XLEN == 32 && (req_funct3 == F3_D || req_funct3 == F3_WU));
   assign err = illegal || misaligned(req_funct3, req_addr[2:0]);

   lsu_align #(.XLEN(XLEN)) u_align (
      .funct3(f3), .lane(lane), .wdata(req_wdata), .rdata(mem_rdata),
      .wmask(wmask), .wdata_sh(wdata_sh), .ldata(ldata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         f3_q          <= '0;
         lane_q        <= '0;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_err      <= 1'b0;
         resp_rdata    <= '0;
         mem_req_valid <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_wmask     <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               f3_q      <= req_funct3;
               lane_q    <= req_addr[LW-1:0];
               req_ready <= 1'b0;
               if (err) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else begin
                  state         <= MREQ;
                  mem_req_valid <= 1'b1;
                  mem_we        <= req_we;
                  mem_addr      <= {req_addr[ADDR_W-1:LW], LW'(0)};
                  mem_wdata     <= wdata_sh;
                  mem_wmask     <= wmask;
               end
            end
            MREQ: if (mem_req_ready) begin
               state         <= MWAIT;
               mem_req_valid <= 1'b0;
            end
            MWAIT: if (mem_resp_valid) begin
               state      <= RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= mem_we ? '0 : ldata;
            end
            RESP: if (resp_ready) begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table plus randomized transactions on XLEN=32 and XLEN=64 instances
module tb_load_store_unit;
   logic clk = 1'b0, rst = 1'b1;
   logic sel64 = 1'b0;
   logic req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
   logic mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
   logic [2:0] req_funct3 = '0;
   logic [31:0] req_addr = '0;
   logic [63:0] req_wdata = '0, mem_rdata = '0;
   int tests = 0, fails = 0;

   logic a_rr, a_rv, a_re, a_mv, a_mwe, b_rr, b_rv, b_re, b_mv, b_mwe;
   logic [31:0] a_rd, a_mwd, a_ma, b_ma;
   logic [63:0] b_rd, b_mwd;
   logic [3:0] a_mm;
   logic [7:0] b_mm;

   load_store_unit #(.XLEN(32)) dut32 (
      .clk(clk), .rst(rst), .req_valid(req_valid & ~sel64), .req_ready(a_rr),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
      .resp_valid(a_rv), .resp_ready(resp_ready), .resp_rdata(a_rd), .resp_err(a_re),
      .mem_req_valid(a_mv), .mem_req_ready(mem_req_ready), .mem_we(a_mwe), .mem_addr(a_ma),
      .mem_wdata(a_mwd), .mem_wmask(a_mm), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata[31:0])
   );
   load_store_unit #(.XLEN(64)) dut64 (
      .clk(clk), .rst(rst), .req_valid(req_valid & sel64), .req_ready(b_rr),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(b_rv), .resp_ready(resp_ready), .resp_rdata(b_rd), .resp_err(b_re),
      .mem_req_valid(b_mv), .mem_req_ready(mem_req_ready), .mem_we(b_mwe), .mem_addr(b_ma),
      .mem_wdata(b_mwd), .mem_wmask(b_mm), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   logic o_rr, o_rv, o_re, o_mv, o_mwe;
   logic [63:0] o_rd, o_mwd;
   logic [31:0] o_ma;
   logic [7:0] o_mm;
   assign o_rr  = sel64 ? b_rr  : a_rr;
   assign o_rv  = sel64 ? b_rv  : a_rv;
   assign o_re  = sel64 ? b_re  : a_re;
   assign o_mv  = sel64 ? b_mv  : a_mv;
   assign o_mwe = sel64 ? b_mwe : a_mwe;
   assign o_rd  = sel64 ? b_rd  : {32'b0, a_rd};
   assign o_mwd = sel64 ? b_mwd : {32'b0, a_mwd};
   assign o_ma  = sel64 ? b_ma  : a_ma;
   assign o_mm  = sel64 ? b_mm  : {4'b0, a_mm};

   always #5 clk = ~clk;

   typedef struct {
      bit x64; bit we; logic [2:0] f3; logic [31:0] addr; logic [63:0] wd, rd;
      bit err; logic [7:0] mask; logic [63:0] ewd, erd; logic [31:0] maddr; int rqs, rss;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference: derived from access size in bytes and byte lane with plain arithmetic
   function automatic void ref_model(input bit x64, input bit we, input logic [2:0] f3,
         input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
         output bit err, output logic [7:0] mask, output logic [63:0] wexp,
         output logic [63:0] rexp, output logic [31:0] maddr);
      int nb, sz, lane;
      bit legal;
      logic [63:0] full, lo, v;
      nb = x64 ? 8 : 4;
      sz = 1 << f3[1:0];
      lane = x64 ? int'(addr[2:0]) : int'(addr[1:0]);
      full = x64 ? '1 : 64'hFFFF_FFFF;
      legal = we ? (!f3[2] && sz <= nb) : (f3 != 3'b111 && sz <= nb && !(f3 == 3'b110 && !x64));
      err = !legal || (lane % sz) != 0;
      mask = 8'(((1 << sz) - 1) << lane);
      wexp = ((wd & full) << (8 * lane)) & full;
      maddr = addr - 32'(lane);
      lo = sz == 8 ? '1 : (64'd1 << (8 * sz)) - 64'd1;
      v = ((rd & full) >> (8 * lane)) & lo;
      if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~lo;
      rexp = (we || err) ? 64'd0 : v & full;
   endfunction

   task automatic run_txn(input vec_t t, input int mdelay, input bit noise);
      sel64 = t.x64; req_we = t.we; req_funct3 = t.f3; req_addr = t.addr; req_wdata = t.wd;
      req_valid = 1'b1;
      #1 chk("req_ready_idle", o_rr, 1);
      @(negedge clk);
      req_valid = 1'b0;
      if (t.err) chk("err_no_mem_req", o_mv, 0);
      else begin
         chk("mem_req_valid", o_mv, 1);
         chk("mem_addr", o_ma, t.maddr);
         chk("mem_wmask", o_mm, t.mask);
         chk("mem_wdata", o_mwd, t.ewd);
         chk("mem_we", o_mwe, t.we);
         chk("req_ready_busy", o_rr, 0);
         for (int k = 0; k < t.rqs; k++) begin
            mem_req_ready = 1'b0;
            mem_resp_valid = noise & 1'($urandom);
            mem_rdata = ~t.rd;
            @(negedge clk);
            chk("stall_mem_req_valid", o_mv, 1);
            chk("stall_mem_addr", o_ma, t.maddr);
            chk("stall_mem_wmask", o_mm, t.mask);
            chk("stall_mem_wdata", o_mwd, t.ewd);
            chk("stall_resp_valid", o_rv, 0);
         end
         mem_req_ready = 1'b1;
         mem_resp_valid = noise;
         mem_rdata = ~t.rd;
         @(negedge clk);
         mem_req_ready = 1'b0;
         mem_resp_valid = 1'b0;
         chk("mem_req_dropped", o_mv, 0);
         chk("early_resp_ignored", o_rv, 0);
         repeat (mdelay) @(negedge clk);
         mem_resp_valid = 1'b1;
         mem_rdata = t.rd;
         @(negedge clk);
         mem_resp_valid = 1'b0;
         mem_rdata = {$urandom, $urandom};
      end
      chk("resp_valid", o_rv, 1);
      chk("resp_err", o_re, t.err);
      chk("resp_rdata", o_rd, t.erd);
      chk("req_ready_resp", o_rr, 0);
      for (int k = 0; k < t.rss; k++) begin
         resp_ready = 1'b0;
         @(negedge clk);
         chk("hold_resp_valid", o_rv, 1);
         chk("hold_resp_rdata", o_rd, t.erd);
         chk("hold_resp_err", o_re, t.err);
         chk("hold_req_ready", o_rr, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("resp_done", o_rv, 0);
      chk("req_ready_back", o_rr, 1);
   endtask

   task automatic chk_reset_state();
      chk("rst_req_ready", o_rr, 1);
      chk("rst_resp_valid", o_rv, 0);
      chk("rst_resp_err", o_re, 0);
      chk("rst_resp_rdata", o_rd, 0);
      chk("rst_mem_req_valid", o_mv, 0);
      chk("rst_mem_we", o_mwe, 0);
      chk("rst_mem_addr", o_ma, 0);
      chk("rst_mem_wdata", o_mwd, 0);
      chk("rst_mem_wmask", o_mm, 0);
   endtask

   vec_t tbl[15];
   vec_t rv;

   initial begin
      tbl[0]  = '{0, 1, 3'b010, 32'h8000_0004, 64'hDEAD_BEEF, 64'h0, 0, 8'h0F, 64'hDEAD_BEEF, 64'h0, 32'h8000_0004, 0, 0};
      tbl[1]  = '{0, 0, 3'b000, 32'h8000_0003, 64'h0, 64'h80FF_1234, 0, 8'h08, 64'h0, 64'hFFFF_FF80, 32'h8000_0000, 0, 0};
      tbl[2]  = '{0, 0, 3'b100, 32'h8000_0003, 64'h0, 64'h80FF_1234, 0, 8'h08, 64'h0, 64'h0000_0080, 32'h8000_0000, 0, 0};
      tbl[3]  = '{0, 0, 3'b101, 32'h8000_0002, 64'h0, 64'h80FF_1234, 0, 8'h0C, 64'h0, 64'h0000_80FF, 32'h8000_0000, 0, 0};
      tbl[4]  = '{0, 1, 3'b001, 32'h8000_0002, 64'h0000_ABCD, 64'h0, 0, 8'h0C, 64'hABCD_0000, 64'h0, 32'h8000_0000, 0, 0};
      tbl[5]  = '{0, 0, 3'b010, 32'h8000_0002, 64'h0, 64'h0, 1, 8'h00, 64'h0, 64'h0, 32'h0, 0, 0};
      tbl[6]  = '{0, 0, 3'b011, 32'h8000_0000, 64'h0, 64'h0, 1, 8'h00, 64'h0, 64'h0, 32'h0, 0, 0};
      tbl[7]  = '{0, 1, 3'b010, 32'h8000_0008, 64'h1234_5678, 64'h0, 0, 8'h0F, 64'h1234_5678, 64'h0, 32'h8000_0008, 3, 2};
      tbl[8]  = '{1, 0, 3'b110, 32'h8000_0004, 64'h0, 64'h89AB_CDEF_0123_4567, 0, 8'hF0, 64'h0, 64'h0000_0000_89AB_CDEF, 32'h8000_0000, 0, 0};
      tbl[9]  = '{1, 0, 3'b011, 32'h8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF, 32'h8000_0008, 0, 0};
      tbl[10] = '{1, 1, 3'b011, 32'h8000_0010, 64'hCAFE_F00D_1234_5678, 64'h0, 0, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'h0, 32'h8000_0010, 0, 0};
      tbl[11] = '{1, 0, 3'b001, 32'h8000_0006, 64'h0, 64'h8001_0000_0000_0000, 0, 8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 32'h8000_0000, 0, 0};
      tbl[12] = '{0, 1, 3'b000, 32'h8000_0001, 64'h1234_5678, 64'h0, 0, 8'h02, 64'h3456_7800, 64'h0, 32'h8000_0000, 0, 0};
      tbl[13] = '{0, 0, 3'b110, 32'h8000_0000, 64'h0, 64'h0, 1, 8'h00, 64'h0, 64'h0, 32'h0, 0, 0};
      tbl[14] = '{1, 1, 3'b011, 32'h8000_0004, 64'h0, 64'h0, 1, 8'h00, 64'h0, 64'h0, 32'h0, 1, 1};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 chk_reset_state();
      sel64 = 1'b1;
      #1 chk_reset_state();
      sel64 = 1'b0;
      mem_resp_valid = 1'b1;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      chk("idle_resp_ignored", o_rv, 0);

      for (int i = 0; i < 15; i++) run_txn(tbl[i], 0, 0);

      // reset while waiting for the memory response; the late response must be dropped
      sel64 = 1'b0; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0010; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_state();
      mem_resp_valid = 1'b1; mem_rdata = 64'h5555_5555;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      chk("post_rst_resp_ignored", o_rv, 0);
      @(negedge clk);
      chk("post_rst_resp_still_0", o_rv, 0);
      run_txn('{0, 0, 3'b010, 32'h8000_0010, 64'h0, 64'hA5A5_0F0F, 0, 8'h0F, 64'h0, 64'hA5A5_0F0F, 32'h8000_0010, 0, 0}, 0, 0);

      for (int i = 0; i < 400; i++) begin
         rv.x64 = 1'($urandom);
         rv.we = 1'($urandom);
         rv.f3 = 3'($urandom);
         if (rv.we && (rv.f3 == 3'b100 || rv.f3 == 3'b101)) rv.f3 = rv.f3 + 3'd2;
         rv.addr = $urandom;
         if ($urandom_range(0, 2) != 0) rv.addr = rv.addr & ~((32'd1 << rv.f3[1:0]) - 32'd1);
         rv.wd = {$urandom, $urandom};
         rv.rd = {$urandom, $urandom};
         rv.rqs = $urandom_range(0, 3);
         rv.rss = $urandom_range(0, 2);
         ref_model(rv.x64, rv.we, rv.f3, rv.addr, rv.wd, rv.rd, rv.err, rv.mask, rv.ewd, rv.erd, rv.maddr);
         if (!rv.x64) rv.mask = rv.mask & 8'h0F;
         run_txn(rv, $urandom_range(0, 2), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
